// File: rtl/vga_sync_gen.sv
// Purpose: VGA raster timing generator (pixel/line counters, hsync/vsync, blanking, line/frame markers).
// Latency: every output is a register decoded from the next position, so all outputs line up with hpos/vpos.
// Backpressure: none; ce=0 freezes all state. Build macro VGA_SYNC_FRAME_CNT_EN adds the 8-bit frame_count port.
module vga_sync_gen #(
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter bit SYNC_POL  = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ce,
  output logic       hsync,
  output logic       vsync,
  output logic       display_on,
  output logic [9:0] hpos,
  output logic [9:0] vpos,
  output logic       line_start,
  output logic       frame_start
`ifdef VGA_SYNC_FRAME_CNT_EN
  ,
  output logic [7:0] frame_count
`endif
);

  // Raster geometry, expressed in the 10-bit counter domain.
  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS      = 10'(H_DISPLAY);
  localparam logic [9:0] V_VIS      = 10'(V_DISPLAY);
  localparam logic [9:0] HS_FIRST   = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_LAST    = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST   = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VS_LAST    = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  // Current position and registered decodes.
  logic [9:0] r_hpos;
  logic [9:0] r_vpos;
  logic       r_hsync;
  logic       r_vsync;
  logic       r_display_on;
  logic       r_line_start;
  logic       r_frame_start;

  // Next position and decodes of that next position.
  logic       w_h_last;
  logic       w_v_last;
  logic       w_frame_wrap;
  logic [9:0] w_hpos_nxt;
  logic [9:0] w_vpos_nxt;
  logic       w_hsync_nxt;
  logic       w_vsync_nxt;
  logic       w_display_on_nxt;
  logic       w_line_start_nxt;
  logic       w_frame_start_nxt;

  // Wrap detection: the last pixel of the last line folds to (0,0) in a single step.
  assign w_h_last     = (r_hpos == H_LAST);
  assign w_v_last     = (r_vpos == V_LAST);
  assign w_frame_wrap = w_h_last & w_v_last;

  // Next-position arithmetic; vpos only moves when the line wraps.
  always_comb begin
    w_hpos_nxt = r_hpos + 10'd1;
    w_vpos_nxt = r_vpos;
    if (w_h_last) begin
      w_hpos_nxt = '0;
      w_vpos_nxt = w_v_last ? '0 : (r_vpos + 10'd1);
    end
  end

  // Decode the next position so the registered outputs match the registered counters.
  always_comb begin
    w_hsync_nxt       = ~SYNC_POL;
    w_vsync_nxt       = ~SYNC_POL;
    if ((w_hpos_nxt >= HS_FIRST) && (w_hpos_nxt <= HS_LAST)) begin
      w_hsync_nxt = SYNC_POL;
    end
    if ((w_vpos_nxt >= VS_FIRST) && (w_vpos_nxt <= VS_LAST)) begin
      w_vsync_nxt = SYNC_POL;
    end
    w_display_on_nxt  = (w_hpos_nxt < H_VIS) && (w_vpos_nxt < V_VIS);
    w_line_start_nxt  = (w_hpos_nxt == 10'd0);
    w_frame_start_nxt = (w_hpos_nxt == 10'd0) && (w_vpos_nxt == 10'd0);
  end

  // Position and decode registers; reset forces (0,0) and its decode, ce gates every update.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hpos        <= '0;
      r_vpos        <= '0;
      r_hsync       <= ~SYNC_POL;
      r_vsync       <= ~SYNC_POL;
      r_display_on  <= 1'b1;
      r_line_start  <= 1'b1;
      r_frame_start <= 1'b1;
    end else if (ce) begin
      r_hpos        <= w_hpos_nxt;
      r_vpos        <= w_vpos_nxt;
      r_hsync       <= w_hsync_nxt;
      r_vsync       <= w_vsync_nxt;
      r_display_on  <= w_display_on_nxt;
      r_line_start  <= w_line_start_nxt;
      r_frame_start <= w_frame_start_nxt;
    end
  end

  assign hpos        = r_hpos;
  assign vpos        = r_vpos;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign display_on  = r_display_on;
  assign line_start  = r_line_start;
  assign frame_start = r_frame_start;

`ifdef VGA_SYNC_FRAME_CNT_EN
  logic [7:0] r_frame_count;

  // Frame counter steps on the same edge that takes the position to (0,0); wraps naturally at 8 bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_frame_count <= '0;
    end else if (ce && w_frame_wrap) begin
      r_frame_count <= r_frame_count + 8'd1;
    end
  end

  assign frame_count = r_frame_count;
`else
  logic w_unused_wrap;
  assign w_unused_wrap = w_frame_wrap;
`endif

endmodule

// File: doc/vga_sync_gen.md
VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- H_DISPLAY, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch
- H_SYNC, 96, hsync pulse width
- H_BACK, 48, horizontal back porch
- V_DISPLAY, 480, visible lines
- V_FRONT, 10, vertical front porch
- V_SYNC, 2, vsync pulse width
- V_BACK, 33, vertical back porch
- SYNC_POL, 0, active level of hsync/vsync (0 = active-low)
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, pixel clock
- reset, in, 1, synchronous active-high reset
- ce, in, 1, pixel advance enable; tie high for one pixel per clock
- hsync, out, 1, horizontal sync
- vsync, out, 1, vertical sync
- display_on, out, 1, current position is visible
- hpos, out, 10, current column
- vpos, out, 10, current line
- line_start, out, 1, high while hpos==0
- frame_start, out, 1, high while hpos==0 and vpos==0
REQ-003 The block SHALL have one clock, clk; reset SHALL be synchronous and active-high.

Function
REQ-004 H_TOTAL SHALL equal H_DISPLAY+H_FRONT+H_SYNC+H_BACK (800 by default); V_TOTAL SHALL equal the V sum (525 by default).
REQ-005 On a clk edge with ce=1, hpos SHALL increment by 1; at hpos==H_TOTAL-1 it SHALL wrap to 0 and vpos SHALL increment.
REQ-006 When hpos and vpos wrap together at (H_TOTAL-1, V_TOTAL-1), the next position SHALL be (0,0) in one edge.
REQ-007 With ce=0, all registers and outputs SHALL hold their values.
REQ-008 All outputs SHALL be registers, decoded from the next position, so every output is aligned with the hpos/vpos it reports (zero latency relative to hpos/vpos).
REQ-009 hsync SHALL be at SYNC_POL exactly while hpos is in [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC-1] (656..751 by default), and at the opposite level otherwise.
REQ-010 vsync SHALL be at SYNC_POL exactly while vpos is in [V_DISPLAY+V_FRONT, V_DISPLAY+V_FRONT+V_SYNC-1] (490..491 by default), over the whole line, and at the opposite level otherwise.
REQ-011 display_on SHALL be 1 if and only if hpos<H_DISPLAY and vpos<V_DISPLAY.
REQ-012 line_start and frame_start SHALL be level decodes of the current position; with ce=0 they stay high for as many cycles as the position holds.
REQ-013 hpos and vpos SHALL never exceed H_TOTAL-1 and V_TOTAL-1.

Reset
REQ-014 With reset=1 at a clk edge: hpos=0, vpos=0, display_on=1, line_start=1, frame_start=1, hsync and vsync at their inactive level.
REQ-015 reset SHALL take priority over ce; reset asserted mid-frame SHALL return the block to (0,0) on the same edge.
REQ-016 On the first edge after reset is released with ce=1, the position SHALL be (1,0).

Configuration
REQ-017 With VGA_SYNC_FRAME_CNT_EN defined, port frame_count (out, 8 bits) SHALL exist.
- It SHALL reset to 0.
- It SHALL increment on the ce edge that wraps (H_TOTAL-1, V_TOTAL-1) to (0,0).
- It SHALL wrap from 255 to 0.
REQ-018 Without VGA_SYNC_FRAME_CNT_EN, port frame_count and its register SHALL be absent, and all other behaviour SHALL be unchanged.

Verification
REQ-019 Reset, then ce=1 for 420000 cycles. Required response:
- line period 800 cycles and frame period 420000 cycles;
- frame_start high once per 420000 cycles;
- display_on high for 307200 cycles per frame.
REQ-020 With default parameters, check the sync windows:
- hsync low exactly for hpos 656..751, i.e. 96 cycles per line;
- vsync low exactly for vpos 490..491, i.e. 1600 cycles per frame.
REQ-021 Toggle ce pseudo-randomly for 2000 cycles. Required response: position advances only on edges with ce=1, and all outputs stay consistent with hpos/vpos.
REQ-022 Assert reset at (399,300) with ce=1. Required response: next output is (0,0), display_on=1, frame_start=1; after release, the next ce edge gives (1,0).
REQ-023 With VGA_SYNC_FRAME_CNT_EN defined, run 257 frames. Required response:
- frame_count reads 255 after frame 255;
- it reads 0 after frame 256 and 1 after frame 257;
- it changes on the same edge as the (0,0) wrap.
REQ-024 With SYNC_POL=1 and H_DISPLAY=64, H_FRONT=4, H_SYNC=8, H_BACK=4. Required response: line period 80 cycles, and hsync high only for hpos 68..75.
